// File: rtl/valve_seq_pkg.sv
// valve_seq_pkg: shared state encoding and default timing constants for the valve sequencer.
package valve_seq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIP  = 2'd1,
        SPRAY = 2'd2,
        DEAD  = 2'd3
    } state_t;
    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_MIN_ON_T = 2000;
    localparam int DEF_DEAD_T   = 500;
    localparam int DEF_BLINK_T  = 250;
endpackage

// File: rtl/valve_seq_if.sv
// valve_seq_if: request levels from the decision logic and solenoid/buzzer drives back.
interface valve_seq_if;
    logic       vs_req;
    logic       bs_req;
    logic       ve_req;
    logic       al_req;
    logic       drip_valve;
    logic       spray_valve;
    logic       inlet_valve;
    logic       alarm_out;
    logic [1:0] state;
    modport master (
        output vs_req, bs_req, ve_req, al_req,
        input  drip_valve, spray_valve, inlet_valve, alarm_out, state
    );
    modport slave (
        input  vs_req, bs_req, ve_req, al_req,
        output drip_valve, spray_valve, inlet_valve, alarm_out, state
    );
endinterface

// File: rtl/valve_tick_gen.sv
// valve_tick_gen: free-running prescaler, one-cycle tick on count TICK_DIV-1.
module valve_tick_gen
    import valve_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == LAST;
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/valve_sequencer.sv
// valve_sequencer: drip/spray interlock with min on-time, dead time and alarm cut-off.
// Define VALVE_SEQ_ALARM_BLINK_EN for a blinking alarm_out; otherwise alarm_out is steady.
module valve_sequencer
    import valve_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MIN_ON_T = DEF_MIN_ON_T,
    parameter int DEAD_T   = DEF_DEAD_T,
    parameter int BLINK_T  = DEF_BLINK_T
) (
    input logic        clk,
    input logic        rst_n,
    valve_seq_if.slave bus
);
    localparam int DMAX = (MIN_ON_T > DEAD_T) ? MIN_ON_T : DEAD_T;
    localparam int CW   = $clog2(DMAX + 1);
    localparam logic [CW-1:0] MIN_C  = CW'(MIN_ON_T);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD_T);
    logic [3:0]    sync1_q, sync2_q;
    logic          vs_s, bs_s, ve_s, al_s;
    logic          tick;
    state_t        state_q, state_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic          drip_q, spray_q, inlet_q, alarm_q, alarm_d;

    assign {vs_s, bs_s, ve_s, al_s} = sync2_q;

    valve_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (vs_s & ~al_s) ? DRIP : (bs_s & ~al_s) ? SPRAY : IDLE;
            DRIP:  state_d = (al_s | (~vs_s & (dwell_q >= MIN_C))) ? DEAD : DRIP;
            SPRAY: state_d = (al_s | (~bs_s & (dwell_q >= MIN_C))) ? DEAD : SPRAY;
            DEAD:  state_d = (dwell_q >= DEAD_C) ? IDLE : DEAD;
        endcase
        dwell_d = (state_d != state_q) ? '0 :
                  (tick && dwell_q != '1) ? dwell_q + 1'b1 : dwell_q;
    end

`ifdef VALVE_SEQ_ALARM_BLINK_EN
    localparam int BW = $clog2(BLINK_T + 1);
    localparam logic [BW-1:0] BLINK_C = BW'(BLINK_T - 1);
    logic [BW-1:0] blink_q, blink_d;
    logic          al_q;
    // al_q is the previous al_s, so ~al_q marks the first cycle of an alarm
    assign blink_d = (!al_s || !al_q) ? '0 :
                     tick ? ((blink_q == BLINK_C) ? '0 : blink_q + 1'b1) : blink_q;
    assign alarm_d = !al_s ? 1'b0 : !al_q ? 1'b1 :
                     (tick && blink_q == BLINK_C) ? ~alarm_q : alarm_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
            al_q    <= 1'b0;
        end else begin
            blink_q <= blink_d;
            al_q    <= al_s;
        end
    end
`else
    assign alarm_d = al_s;
`endif

    // valve drives decode the next state so they change in the same cycle as the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            dwell_q <= '0;
            drip_q  <= 1'b0;
            spray_q <= 1'b0;
            inlet_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            sync1_q <= {bus.vs_req, bus.bs_req, bus.ve_req, bus.al_req};
            sync2_q <= sync1_q;
            state_q <= state_d;
            dwell_q <= dwell_d;
            drip_q  <= state_d == DRIP;
            spray_q <= state_d == SPRAY;
            inlet_q <= ve_s;
            alarm_q <= alarm_d;
        end
    end

    assign bus.drip_valve  = drip_q;
    assign bus.spray_valve = spray_q;
    assign bus.inlet_valve = inlet_q;
    assign bus.alarm_out   = alarm_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_valve_sequencer.sv
// tb_valve_sequencer: random request levels against a sampled-history reference model with a scoreboard.
module tb_valve_sequencer;
    localparam int TD = 4, MIN_ON = 3, DEAD = 2, BLINK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0;

    valve_seq_if vif();

    valve_sequencer #(
        .TICK_DIV(TD), .MIN_ON_T(MIN_ON), .DEAD_T(DEAD), .BLINK_T(BLINK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] st; logic drip, spray, inlet, alarm;} exp_t;
    typedef struct packed {logic vs, bs, ve, al;} req_t;

    exp_t sb[$];
    req_t hist[$];
    int   m, mode, dwell;
`ifdef VALVE_SEQ_ALARM_BLINK_EN
    int   age;
`endif

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t outs();
        return exp_t'({vif.state, vif.drip_valve, vif.spray_valve, vif.inlet_valve, vif.alarm_out});
    endfunction

    // Reference: a request is seen two edges after it is sampled; modes 0..3 follow the sequencing rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            hist.delete();
            repeat (3) hist.push_back('0);
            m = 0; mode = 0; dwell = 0;
`ifdef VALVE_SEQ_ALARM_BLINK_EN
            age = 0;
`endif
        end else begin : model
            req_t s, sp;
            bit   tk;
            int   nxt;
            exp_t e;
            m++;
            hist.push_back(req_t'({vif.vs_req, vif.bs_req, vif.ve_req, vif.al_req}));
            s  = hist[hist.size()-3];
            sp = hist[hist.size()-4];
            if (hist.size() > 4) void'(hist.pop_front());
            tk = ((m - 1) % TD) == TD - 1;
            nxt = mode;
            if (mode == 0) nxt = (s.vs && !s.al) ? 1 : (s.bs && !s.al) ? 2 : 0;
            else if (mode == 3) nxt = (dwell >= DEAD) ? 0 : 3;
            else if (s.al || (!(mode == 1 ? s.vs : s.bs) && dwell >= MIN_ON)) nxt = 3;
            dwell = (nxt != mode) ? 0 : dwell + int'(tk);
            mode  = nxt;
            e.st    = 2'(mode);
            e.drip  = mode == 1;
            e.spray = mode == 2;
            e.inlet = s.ve;
`ifdef VALVE_SEQ_ALARM_BLINK_EN
            age = (!s.al || !sp.al) ? 0 : age + int'(tk);
            e.alarm = s.al && ((age / BLINK) % 2 == 0);
`else
            e.alarm = s.al;
`endif
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin : monitor
            exp_t e, a;
            e = sb.pop_front();
            a = outs();
            chk("outputs", a, e);
            chk("exclusive", {5'd0, a.drip & a.spray}, 6'd0);
        end
    end

    task automatic drive(input logic vs, input logic bs, input logic ve, input logic al);
        vif.vs_req = vs; vif.bs_req = bs; vif.ve_req = ve; vif.al_req = al;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 6'd0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1, 1, 1, 1);
        cyc(3);
        chk("in_reset", outs(), 6'd0);
        drive(1, 1, 0, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("drip_2clk", {5'd0, vif.drip_valve}, 6'd0);
        cyc(1);
        chk("drip_3clk", {5'd0, vif.drip_valve}, 6'd1);
        cyc(20);
        drive(0, 1, 0, 0);
        cyc(40);
        drive(0, 0, 0, 0);
        cyc(30);
        drive(1, 0, 0, 0);
        cyc(8);
        drive(0, 0, 1, 0);
        cyc(40);
        drive(0, 1, 0, 0);
        cyc(9);
        drive(0, 1, 0, 1);
        cyc(40);
        drive(0, 0, 0, 0);
        cyc(30);
        drive(1, 0, 0, 0);
        cyc(10);
        async_reset();
        cyc(12);
        drive(1, 0, 0, 1);
        cyc(5);
        chk("dead_before_reset", {4'd0, vif.state}, 6'd3);
        async_reset();
        drive(0, 0, 0, 0);
        cyc(10);
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 39) == 0) async_reset();
            cyc($urandom_range(1, 25));
        end
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/valve_sequencer.md
# valve_sequencer

Registered actuator stage directly downstream of the combinational irrigation decision logic. Takes its drip (Vs), sprinkler (Bs), inlet-valve (Ve) and alarm (Al) request levels and drives the physical solenoids and buzzer. Enforces mutual exclusion between drip and sprinkler, a minimum on-time, and a break-before-make dead time. Adds an emergency cut-off on alarm and produces a blinking alarm output.

## Interface
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); ≥2
- MIN_ON_T, 2000, minimum irrigation on-time, in ticks; ≥1
- DEAD_T, 500, off-time between any irrigation stop and the next start, in ticks; ≥1
- BLINK_T, 250, alarm half-period, in ticks; ≥1
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vs_req  in  1  drip request from decision logic (asynchronous level)
- bs_req  in  1  sprinkler request (asynchronous level)
- ve_req  in  1  inlet-valve request (asynchronous level)
- al_req  in  1  alarm request (asynchronous level)
- drip_valve  out  1  drip solenoid drive
- spray_valve  out  1  sprinkler solenoid drive
- inlet_valve  out  1  tank inlet solenoid drive
- alarm_out  out  1  buzzer/LED drive
- state  out  2  current FSM state, for display/debug

## Operation
- All four requests pass through a 2-FF synchroniser; all logic below uses the synchronised copies (vs_s, bs_s, ve_s, al_s).
- The tick generator is a free-running prescaler counting 0..TICK_DIV-1. It emits a one-cycle tick when it reaches TICK_DIV-1, then wraps to 0.
- FSM states: IDLE=0, DRIP=1, SPRAY=2, DEAD=3.
- IDLE → DRIP when vs_s & ~al_s. Otherwise IDLE → SPRAY when bs_s & ~vs_s & ~al_s. Drip wins if both requests are high.
- DRIP → DEAD when al_s, immediately, ignoring the min-on rule. Also DRIP → DEAD when ~vs_s and on_cnt ≥ MIN_ON_T.
- SPRAY → DEAD under the same rules, using bs_s.
- DEAD → IDLE when dead_cnt ≥ DEAD_T. Requests are ignored while in DEAD.
- Dwell counter: cleared on every state entry, increments on tick, saturates at its maximum value. Width is $clog2(max(MIN_ON_T, DEAD_T) + 1).
- drip_valve = (state == DRIP); spray_valve = (state == SPRAY). Both outputs are registered and are never high together.
- inlet_valve = registered ve_s. It is independent of the FSM.
- Alarm: while al_s is high, alarm_out toggles every BLINK_T ticks, starting high on the first cycle al_s is seen. The blink counter is cleared when al_s falls. alarm_out = 0 whenever al_s = 0.
- Reset, asynchronous at any time including mid-DRIP or mid-DEAD: state=IDLE, all counters=0, synchronisers=0, all outputs 0.

## Timing
- Latency from a request edge to drip_valve/spray_valve from IDLE: 3 clk (2 sync + 1 register).
- Latency from a ve_req edge to inlet_valve: 3 clk.
- Latency from an al_req rise to valve cut: 3 clk from DRIP/SPRAY (valve low in the same cycle as the DEAD entry).
- Dwell times are measured in ticks, with jitter of up to one tick minus one cycle, because the prescaler is not reset on state entry.
- A request toggling shorter than 2 clk may be missed. This is acceptable behaviour.

## Configuration
- VALVE_SEQ_ALARM_BLINK_EN defined: alarm_out blinks as described, and the blink counter is instantiated.
- VALVE_SEQ_ALARM_BLINK_EN undefined: alarm_out = registered al_s (steady), and no blink counter exists.

## Structure
- Package valve_seq_pkg: state enum (IDLE/DRIP/SPRAY/DEAD, 2-bit) and default parameter constants.
- Sub-module valve_tick_gen: parameterised prescaler producing the tick pulse.
- Synchronisers, FSM, dwell counter and alarm logic stay in valve_sequencer.

## Test plan
Bench parameters: TICK_DIV=4, MIN_ON_T=3, DEAD_T=2, BLINK_T=2.
- Reset: hold rst_n=0 with all requests=1 → all outputs 0, state=0. Release reset → drip_valve=1 exactly 3 clk later.
- Short drip: pulse vs_req for 2 ticks → drip_valve stays high ≥3 ticks. Then state=3 for ~2 ticks, then state=0. spray_valve is never 1.
- Changeover: vs_req 1→0 and bs_req 0→1 in the same cycle after min-on → drip_valve falls, then a ≥2-tick gap with both valves 0, then spray_valve=1.
- Emergency: assert al_req mid-SPRAY after 1 tick → spray_valve=0 3 clk later despite min-on. alarm_out=1, then toggles every 8 clk. No restart while al_req=1.
- Simultaneous requests: vs_req=bs_req=1 from IDLE → DRIP is selected. Drop vs_req → after DEAD, SPRAY follows.
- Reset mid-operation: assert rst_n=0 during DEAD and during DRIP → outputs clear asynchronously. With VALVE_SEQ_ALARM_BLINK_EN undefined, alarm_out tracks al_req steadily with 3 clk latency.
